serial_pattern_detector: RTL and testbench

Parametrised serial sequence detector. It is the successor to the fixed 2-bit-state Mealy zero detector.
- Accepts a qualified serial bit stream and compares it against a runtime-loadable PAT_W-bit pattern.
- Provides a combinational Mealy match output, a registered Moore-style copy, and a saturating match counter.
- Selectable overlapping or non-overlapping detection.
- Sits between the serial front end and the lab status/LED logic.

---
 rtl/spd_pkg.sv | 17 +
 rtl/serial_pattern_detector_if.sv | 29 ++
 rtl/sat_counter.sv | 42 ++++
 rtl/serial_pattern_detector.sv | 83 ++++++++
 tb/tb_serial_pattern_detector.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/spd_pkg.sv
// Shared constants and types for the serial pattern detector family.
package spd_pkg;

    // Default geometry of the detector and its match counter.
    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    // Pattern loaded at reset: the sequence 1,1,1,0 (MSB is the oldest bit).
    localparam logic [3:0] PAT_RESET_DEF = 4'b1110;

    // Fill state, kept as a named type so waveforms show FILL/RUN.
    typedef enum logic {
        FILL = 1'b0,  // history not yet holding PAT_W-1 valid bits
        RUN  = 1'b1   // history full; every valid bit can complete a match
    } fill_state_e;

endpackage

// File: rtl/serial_pattern_detector_if.sv
// Bit-stream, pattern-load and status signals of the serial pattern detector.
interface serial_pattern_detector_if
    import spd_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             x_valid;
    logic             x_in;
    logic             pat_load;
    logic [PAT_W-1:0] pattern_in;
    logic             clear_count;
    logic             y_out;
    logic             y_reg;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    // Source of the bit stream and consumer of the status outputs.
    modport master (
        output x_valid, x_in, pat_load, pattern_in, clear_count,
        input  y_out, y_reg, match_count, count_sat
    );

    // The detector itself.
    modport slave (
        input  x_valid, x_in, pat_load, pattern_in, clear_count,
        output y_out, y_reg, match_count, count_sat
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins) and a registered
// all-ones flag.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);
    logic [CNT_W-1:0] count_d, count_q;
    logic             sat_d, sat_q;

    // Next count: clear first, otherwise step unless already at all-ones.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !sat_q) begin
            count_d = count_q + CNT_W'(1);
        end
        sat_d = &count_d;
    end

    // Count and flag registered together so they never disagree.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;
endmodule

// File: rtl/serial_pattern_detector.sv
// Parametrised serial sequence detector: Mealy match, registered copy and a
// saturating match counter, with runtime-loadable pattern.
module serial_pattern_detector
    import spd_pkg::*;
#(
    parameter int               PAT_W     = PAT_W_DEF,  // legal range 2..16
    parameter int               CNT_W     = CNT_W_DEF,
    parameter bit               OVERLAP   = 1'b1,
    parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(PAT_RESET_DEF)
) (
    input  logic                      clock,
    input  logic                      reset,
    serial_pattern_detector_if.slave  bus
);
    localparam int               FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pattern_d, pattern_q;
    logic [PAT_W-2:0]  hist_d, hist_q;
    logic [FILL_W-1:0] fill_d, fill_q;
    logic              y_reg_d, y_reg_q;
    logic [PAT_W-1:0]  window;
    logic              match;
    fill_state_e       state;

    // Oldest bits in hist, the presented bit completes the window.
    assign window = {hist_q, bus.x_in};
    assign state  = (fill_q == FILL_LAST) ? RUN : FILL;

    // Mealy match and next-state for pattern, history and fill level.
    always_comb begin
        match     = (state == RUN) && bus.x_valid && !bus.pat_load && (window == pattern_q);
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        y_reg_d   = match;
        if (bus.pat_load) begin
            // A new pattern invalidates all history; the bit in this cycle is dropped.
            pattern_d = bus.pattern_in;
            hist_d    = '0;
            fill_d    = '0;
        end else if (bus.x_valid) begin
            if (match && !OVERLAP) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PAT_W-2:0];
                if (state == FILL) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
        end
    end

    // Detector state and registered match copy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern_q <= PAT_RESET;
            hist_q    <= '0;
            fill_q    <= '0;
            y_reg_q   <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            y_reg_q   <= y_reg_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (match),
        .clr   (bus.clear_count),
        .count (bus.match_count),
        .sat   (bus.count_sat)
    );

    assign bus.y_out = match;
    assign bus.y_reg = y_reg_q;
endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench: three detectors fed the same stream --
// a: overlapping, 8-bit count; b: non-overlapping; c: overlapping, 2-bit count.
module tb_serial_pattern_detector;
    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    serial_pattern_detector_if #(.PAT_W(4), .CNT_W(8)) if_a ();
    serial_pattern_detector_if #(.PAT_W(4), .CNT_W(8)) if_b ();
    serial_pattern_detector_if #(.PAT_W(4), .CNT_W(2)) if_c ();

    serial_pattern_detector #(.PAT_W(4), .CNT_W(8), .OVERLAP(1'b1)) dut_a (
        .clock (clock), .reset (reset), .bus (if_a.slave));
    serial_pattern_detector #(.PAT_W(4), .CNT_W(8), .OVERLAP(1'b0)) dut_b (
        .clock (clock), .reset (reset), .bus (if_b.slave));
    serial_pattern_detector #(.PAT_W(4), .CNT_W(2), .OVERLAP(1'b1)) dut_c (
        .clock (clock), .reset (reset), .bus (if_c.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Same inputs to all three detectors.
    task automatic drive(input logic v, input logic b, input logic ld,
                         input logic [3:0] p, input logic clr);
        if_a.x_valid = v; if_a.x_in = b; if_a.pat_load = ld; if_a.pattern_in = p; if_a.clear_count = clr;
        if_b.x_valid = v; if_b.x_in = b; if_b.pat_load = ld; if_b.pattern_in = p; if_b.clear_count = clr;
        if_c.x_valid = v; if_c.x_in = b; if_c.pat_load = ld; if_c.pattern_in = p; if_c.clear_count = clr;
    endtask

    // Entered at posedge+1: drive, check Mealy outputs mid-cycle, advance one edge.
    task automatic feed(input string tag, input logic v, input logic b, input logic clr,
                        input logic ya, input logic yb, input logic yc);
        drive(v, b, 1'b0, 4'h0, clr);
        #1;
        check({tag, " y_out a"}, 32'(if_a.y_out), 32'(ya));
        check({tag, " y_out b"}, 32'(if_b.y_out), 32'(yb));
        check({tag, " y_out c"}, 32'(if_c.y_out), 32'(yc));
        @(posedge clock); #1;
    endtask

    task automatic load(input string tag, input logic v, input logic b, input logic [3:0] p,
                        input logic clr);
        drive(v, b, 1'b1, p, clr);
        #1;
        check({tag, " load y_out a"}, 32'(if_a.y_out), 32'd0);
        check({tag, " load y_out b"}, 32'(if_b.y_out), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic clear_cycle();
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic counts(input string tag, input int ca, input int cb, input int cc, input logic sc);
        check({tag, " count a"}, 32'(if_a.match_count), 32'(ca));
        check({tag, " count b"}, 32'(if_b.match_count), 32'(cb));
        check({tag, " count c"}, 32'(if_c.match_count), 32'(cc));
        check({tag, " sat c"},   32'(if_c.count_sat),   32'(sc));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check("rst y_out", 32'(if_a.y_out), 32'd0);
        check("rst y_reg", 32'(if_a.y_reg), 32'd0);
        counts("rst", 0, 0, 0, 1'b0);
        #3 reset = 1'b0;
        @(posedge clock); #1;

        // Reset pattern is 1110.
        feed("dflt1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("dflt2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("dflt3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("dflt4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("dflt y_reg a", 32'(if_a.y_reg), 32'd1);
        counts("dflt", 1, 1, 1, 1'b0);
        feed("dflt idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("dflt y_reg drop", 32'(if_a.y_reg), 32'd0);

        // Partial 1,1,1 then async reset mid-cycle; history must be gone.
        feed("mid1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("mid2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("mid3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #4 reset = 1'b1;
        #1;
        check("async y_out", 32'(if_a.y_out), 32'd0);
        counts("async", 0, 0, 0, 1'b0);
        @(posedge clock);
        #4 reset = 1'b0;
        @(posedge clock); #1;
        feed("post0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("post1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("post2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("post3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("post4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        counts("post", 1, 1, 1, 1'b0);

        // Valid gaps do not break a sequence.
        clear_cycle();
        load("gap", 1'b0, 1'b0, 4'b1110, 1'b0);
        feed("gap1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("gap2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            feed("gapidle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        feed("gap3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("gap4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        counts("gap", 1, 1, 1, 1'b0);

        // Overlap: 1010 over 1,0,1,0,1,0 -> a,c match on bits 4 and 6, b on 4 only.
        load("ovl", 1'b0, 1'b0, 4'b1010, 1'b1);
        feed("ovl1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("ovl2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("ovl3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("ovl4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        feed("ovl5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("ovl6", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        counts("ovl", 2, 1, 2, 1'b0);

        // Load priority: history 101 would match 1010 on a 0, but the load wins.
        feed("ld pre", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        load("ld0", 1'b1, 1'b0, 4'b0011, 1'b0);
        load("ld1", 1'b1, 1'b1, 4'b0011, 1'b0);
        counts("ld", 2, 1, 2, 1'b0);
        feed("ld s1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("ld s2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("ld s3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("ld s4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        counts("ld post", 3, 2, 3, 1'b1);

        // Saturation: five 0011 matches; 2-bit counter sticks at 3.
        clear_cycle();
        counts("clr", 0, 0, 0, 1'b0);
        for (int m = 0; m < 5; m++) begin
            feed("sat s1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            feed("sat s2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            feed("sat s3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            feed("sat s4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            if (m == 1) counts("sat two", 2, 2, 2, 1'b0);
        end
        counts("sat", 5, 5, 3, 1'b1);

        // Clear in the same cycle as a match: count 0, y_reg still set.
        feed("cm1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("cm2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("cm3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("cm4", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("cm y_reg c", 32'(if_c.y_reg), 32'd1);
        check("cm y_reg a", 32'(if_a.y_reg), 32'd1);
        counts("cm", 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
